// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad row scanner with press/release debounce and two-digit history
module keypad_scanner #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 480000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] row_select,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t        state, state_n;
    logic [SW-1:0] scan_cnt, scan_cnt_n;
    logic [DW-1:0] db_cnt, db_cnt_n;
    logic [1:0]    cur_row, cur_row_n;
    logic [1:0]    col_idx, col_idx_n;
    logic [2:0]    col_meta, col_s;
    logic [3:0]    key_code_n, digit_new_n, digit_old_n;
    logic          key_valid_n, key_held_n;
    logic          sel_low;
    logic [1:0]    lowest_col;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_map = 4'h1;
            4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;
            4'h4: key_map = 4'h4;
            4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;
            4'h8: key_map = 4'h7;
            4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;
            4'hC: key_map = 4'hE;
            4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;
            default: key_map = 4'h0;
        endcase
    endfunction

    // The driven row is kept as an index so a frozen row is simply an unchanged index.
    assign row_select = ~(4'b0001 << cur_row);

    always_comb begin
        case (col_idx)
            2'd0:    sel_low = ~col_s[0];
            2'd1:    sel_low = ~col_s[1];
            default: sel_low = ~col_s[2];
        endcase
        if (!col_s[0])      lowest_col = 2'd0;
        else if (!col_s[1]) lowest_col = 2'd1;
        else                lowest_col = 2'd2;
    end

    always_comb begin
        state_n     = state;
        scan_cnt_n  = scan_cnt;
        db_cnt_n    = db_cnt;
        cur_row_n   = cur_row;
        col_idx_n   = col_idx;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        digit_new_n = digit_new;
        digit_old_n = digit_old;
        case (state)
            SCAN: begin
                if (scan_cnt == SCAN_LAST) begin
                    scan_cnt_n = '0;
                    if (col_s == 3'b111) begin
                        cur_row_n = cur_row + 2'd1;
                    end else begin
                        col_idx_n = lowest_col;
                        db_cnt_n  = '0;
                        state_n   = DEBOUNCE;
                    end
                end else begin
                    scan_cnt_n = scan_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (!sel_low) begin
                    state_n    = SCAN;
                    cur_row_n  = cur_row + 2'd1;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n     = HELD;
                    db_cnt_n    = '0;
                    key_valid_n = 1'b1;
                    key_held_n  = 1'b1;
                    key_code_n  = key_map(cur_row, col_idx);
                    digit_old_n = digit_new;
                    digit_new_n = key_map(cur_row, col_idx);
                end else begin
                    db_cnt_n = db_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!sel_low) begin
                    state_n  = RELEASE;
                    db_cnt_n = '0;
                end
            end
            RELEASE: begin
                if (sel_low) begin
                    state_n  = HELD;
                    db_cnt_n = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n    = SCAN;
                    key_held_n = 1'b0;
                    cur_row_n  = cur_row + 2'd1;
                    scan_cnt_n = '0;
                    db_cnt_n   = '0;
                end else begin
                    db_cnt_n = db_cnt + DW'(1);
                end
            end
            default: state_n = SCAN;
        endcase
    end

    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            scan_cnt  <= '0;
            db_cnt    <= '0;
            cur_row   <= 2'd0;
            col_idx   <= 2'd0;
            col_meta  <= 3'b111;
            col_s     <= 3'b111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            digit_new <= 4'h0;
            digit_old <= 4'h0;
        end else begin
            state     <= state_n;
            scan_cnt  <= scan_cnt_n;
            db_cnt    <= db_cnt_n;
            cur_row   <= cur_row_n;
            col_idx   <= col_idx_n;
            col_meta  <= col;
            col_s     <= col_meta;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
            digit_new <= digit_new_n;
            digit_old <= digit_old_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed bench for keypad_scanner with a row-gated keypad model
module tb_keypad_scanner;

    logic       int_osc = 1'b0;
    logic       reset;
    logic [2:0] col;
    logic [3:0] row_select;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [11:0] keys;
    int          checks = 0;
    int          failures = 0;
    int          kv_count = 0;
    logic        found;

    keypad_scanner #(.SCAN_DIV(8), .DEBOUNCE_CYCLES(16)) dut (
        .int_osc    (int_osc),
        .reset      (reset),
        .col        (col),
        .row_select (row_select),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_held   (key_held),
        .digit_new  (digit_new),
        .digit_old  (digit_old)
    );

    always #5 int_osc = ~int_osc;

    // Key bit index is row*3+col; a pressed key pulls its column low only while its row is driven.
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r*3+c] && !row_select[r]) col[c] = 1'b0;
    end

    always @(posedge int_osc) if (key_valid === 1'b1) kv_count++;

    task automatic tick(input int n);
        repeat (n) @(negedge int_osc);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_kv(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge int_osc);
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge int_osc);
            if (key_held === 1'b0) ok = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b0;
        keys  = 12'h000;
        tick(3);
        check("rst_row", row_select, 4'b1110);
        check("rst_code", key_code, 4'h0);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held", key_held, 1'b0);
        check("rst_dnew", digit_new, 4'h0);
        check("rst_dold", digit_old, 4'h0);

        reset = 1'b1;
        tick(7);
        check("scan_r0_hold", row_select, 4'b1110);
        tick(1);
        check("scan_r1", row_select, 4'b1101);
        tick(8);
        check("scan_r2", row_select, 4'b1011);
        tick(8);
        check("scan_r3", row_select, 4'b0111);
        tick(8);
        check("scan_wrap", row_select, 4'b1110);

        keys[4] = 1'b1;
        tick(31);
        check("k5_pre_valid", key_valid, 1'b0);
        check("k5_pre_row", row_select, 4'b1101);
        tick(1);
        check("k5_valid", key_valid, 1'b1);
        check("k5_code", key_code, 4'h5);
        check("k5_dnew", digit_new, 4'h5);
        check("k5_dold", digit_old, 4'h0);
        check("k5_held", key_held, 1'b1);
        check("k5_frozen", row_select, 4'b1101);
        tick(1);
        check("k5_strobe_1cyc", key_valid, 1'b0);
        check("k5_held_on", key_held, 1'b1);
        keys[4] = 1'b0;
        tick(18);
        check("k5_rel_pending", key_held, 1'b1);
        tick(1);
        check("k5_released", key_held, 1'b0);
        check("k5_rel_row", row_select, 4'b1011);
        check("k5_one_pulse", kv_count, 1);

        keys[8] = 1'b1;
        tick(13);
        keys[8] = 1'b0;
        tick(2);
        check("bnc1_frozen", row_select, 4'b1011);
        tick(1);
        check("bnc1_resume", row_select, 4'b0111);
        keys[9] = 1'b1;
        tick(7);
        keys[9] = 1'b0;
        tick(2);
        check("bnc2_frozen", row_select, 4'b0111);
        tick(1);
        check("bnc2_resume", row_select, 4'b1110);
        check("bnc_no_valid", kv_count, 1);
        check("bnc_no_held", key_held, 1'b0);

        keys[0] = 1'b1;
        wait_kv(100, found);
        check("k1_seen", found, 1'b1);
        check("k1_code", key_code, 4'h1);
        check("k1_dnew", digit_new, 4'h1);
        check("k1_dold", digit_old, 4'h5);
        keys[0] = 1'b0;
        wait_release(100, found);
        check("k1_release", found, 1'b1);
        keys[11] = 1'b1;
        wait_kv(200, found);
        check("khash_seen", found, 1'b1);
        check("khash_code", key_code, 4'hF);
        check("khash_dnew", digit_new, 4'hF);
        check("khash_dold", digit_old, 4'h1);
        keys[11] = 1'b0;
        wait_release(100, found);
        check("khash_release", found, 1'b1);
        check("two_pulses", kv_count, 3);

        keys[4] = 1'b1;
        wait_kv(200, found);
        check("k5b_seen", found, 1'b1);
        check("k5b_dnew", digit_new, 4'h5);
        check("k5b_dold", digit_old, 4'hF);
        tick(2);
        keys[3] = 1'b1;
        keys[4] = 1'b0;
        tick(4);
        keys[4] = 1'b1;
        tick(20);
        check("multi_held", key_held, 1'b1);
        check("multi_no_valid", kv_count, 4);
        check("multi_code", key_code, 4'h5);
        keys = 12'h000;
        tick(18);
        check("multi_rel_pending", key_held, 1'b1);
        tick(1);
        check("multi_released", key_held, 1'b0);
        check("multi_rel_row", row_select, 4'b1011);

        keys[7] = 1'b1;
        wait_kv(200, found);
        check("k8_seen", found, 1'b1);
        check("k8_dnew", digit_new, 4'h8);
        check("k8_dold", digit_old, 4'h5);
        tick(5);
        #2 reset = 1'b0;
        #1;
        check("midrst_held", key_held, 1'b0);
        check("midrst_code", key_code, 4'h0);
        check("midrst_dnew", digit_new, 4'h0);
        check("midrst_dold", digit_old, 4'h0);
        check("midrst_row", row_select, 4'b1110);
        check("midrst_valid", key_valid, 1'b0);
        tick(2);
        reset = 1'b1;
        wait_kv(200, found);
        check("k8r_seen", found, 1'b1);
        check("k8r_code", key_code, 4'h8);
        check("k8r_dnew", digit_new, 4'h8);
        check("k8r_dold", digit_old, 4'h0);
        tick(40);
        check("k8r_once", kv_count, 6);
        check("k8r_held", key_held, 1'b1);
        keys = 12'h000;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Upstream stage for the keypad/dual-display path. It drives the 4x3 keypad rows one at a time and samples the columns through a synchronizer. It debounces both press and release, then encodes the key. It outputs a one-cycle key strobe and a two-digit history (newest and previous key) for the seven-segment display multiplexer downstream. It accepts only one key at a time and never auto-repeats.

Parameters:
SCAN_DIV, 4096, clock cycles each row is driven before its columns are evaluated; must be >= 4.
DEBOUNCE_CYCLES, 480000, consecutive stable cycles required to accept a press or a release (20 ms at 24 MHz); must be >= 2.

Ports:
int_osc  input  1  system clock (HSOSC output)
reset  input  1  asynchronous, active-low reset
col  input  3  keypad columns, active-low (pulled up externally), asynchronous to int_osc
row_select  output  4  row drive, active-low one-hot (exactly one bit 0 at all times)
key_code  output  4  code of last accepted key
key_valid  output  1  one-cycle strobe when a new key is accepted
key_held  output  1  high from acceptance until release is debounced
digit_new  output  4  most recent accepted key code
digit_old  output  4  key code accepted before digit_new

Behaviour:
- Reset (async assert, sync deassert use): row_select=4'b1110, state SCAN, all counters 0, key_code=0, key_valid=0, key_held=0, digit_new=0, digit_old=0, synchronizer flops=3'b111.
- col passes through a 2-flop synchronizer (col_s). All decisions use col_s.
- Key map (row index, col index -> code):
  - r0: 1,2,3
  - r1: 4,5,6
  - r2: 7,8,9
  - r3: '*'=0xE, 0=0x0, '#'=0xF
- Row index r corresponds to row_select bit r low.
- State SCAN:
  - scan_cnt counts 0..SCAN_DIV-1.
  - At terminal count with col_s==3'b111: rotate row_select (r0->r1->r2->r3->r0) and clear scan_cnt.
  - At terminal count with any col_s bit low: latch row index and lowest-index low column, clear db_cnt, go DEBOUNCE. row_select frozen.
- State DEBOUNCE:
  - Each cycle the latched column bit is low, db_cnt increments.
  - If the latched column reads high: go SCAN, rotate row, clear scan_cnt. No outputs change.
  - When db_cnt reaches DEBOUNCE_CYCLES-1 with the bit still low: go HELD and, on that same edge, register all of the following:
    - key_valid=1 for exactly one cycle
    - key_code=code
    - digit_old<=digit_new
    - digit_new<=code
    - key_held=1
- State HELD:
  - row_select stays frozen; other columns and rows are ignored.
  - Latched column bit high: clear db_cnt, go RELEASE.
- State RELEASE:
  - Bit low again before count completes: return to HELD, with no new key_valid and no history change.
  - db_cnt reaches DEBOUNCE_CYCLES-1 with the bit high: go SCAN, key_held=0, rotate row, clear scan_cnt.
- Simultaneous keys:
  - Same row: lowest column index wins.
  - Different rows: the first row reached in scan order wins.
- key_code and the digit registers hold their values until the next accepted press.
- Reset asserted in any state returns immediately to reset values. A key still held after reset deassertion is re-detected through a full press debounce and produces a fresh key_valid.
- Counter widths: $clog2 of the respective parameter. Counters never wrap silently; they are cleared on every state change.

Test Plan:
(All with SCAN_DIV=8, DEBOUNCE_CYCLES=16.)
1. Reset low, then release with col=3'b111 -> row_select=1110, all outputs 0. row_select steps 1101, 1011, 0111, 1110 every 8 cycles.
2. Hold col[1] low only while row_select=1101 (key '5'), stably -> one key_valid pulse ~16 cycles after detection, key_code=5, digit_new=5, digit_old=0, key_held=1, row_select frozen at 1101.
3. Press/release bounce (col low for 5 cycles, high, low for 7, high) -> no key_valid, scanning resumes with the next row.
4. Press '1' then '#' (each with full press and release) -> after second strobe digit_old=1, digit_new=0xF, key_code=0xF. Exactly two key_valid pulses.
5. While '5' held, also drive col[0] low in the same row and bounce col[1] high for 4 cycles -> no new key_valid, key_held stays 1. After col[1] stays high 16 cycles, key_held=0 and scanning resumes.
6. Assert reset mid-HELD with key '8' still pressed -> outputs clear immediately. After deassertion the key is rescanned and key_valid fires once with digit_new=8, digit_old=0.
